// File: rtl/pwm_audio_stereo_output_if.sv
// Sample/PWM bundle between the audio sample source and the stereo PWM DAC driver.
interface pwm_audio_stereo_output_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] left_top;
    logic [WIDTH-1:0] right_top;
    logic             left;
    logic             right;

    modport master (
        output left_top,
        output right_top,
        input  left,
        input  right
    );

    modport slave (
        input  left_top,
        input  right_top,
        output left,
        output right
    );
endinterface

// File: rtl/pwm_audio_stereo_output.sv
// Two-channel PWM DAC driver. Both channels share one period counter of
// 2^WIDTH-1 clocks; samples are latched only at the period boundary so a
// mid-period sample change never produces a glitch on the output.
module pwm_audio_stereo_output #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      aclr,
    pwm_audio_stereo_output_if.slave  bus
);
    // Last counter value; the counter skips all-ones so duty reaches 100%.
    localparam logic [WIDTH-1:0] MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lat_l;
    logic [WIDTH-1:0] lat_r;
    logic             left_q;
    logic             right_q;
    logic             at_max;

    assign at_max = (cnt == MAX);

    // Free-running period counter, wraps from MAX back to zero.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt <= '0;
        end else begin
            cnt <= at_max ? '0 : cnt + 1'b1;
        end
    end

    // Sample latches, loaded at the boundary so new duty starts at cnt==0.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            lat_l <= '0;
            lat_r <= '0;
        end else if (at_max) begin
            lat_l <= bus.left_top;
            lat_r <= bus.right_top;
        end
    end

    // Registered comparators; outputs trail the counter by one clock.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            left_q  <= (cnt < lat_l);
            right_q <= (cnt < lat_r);
        end
    end

    assign bus.left  = left_q;
    assign bus.right = right_q;
endmodule

// File: tb/tb_pwm_audio_stereo_output.sv
// Directed bench for the stereo PWM driver: whole periods are checked
// sample-by-sample against the expected duty for each channel.
module tb_pwm_audio_stereo_output;
    localparam int unsigned W      = 8;
    localparam int          PERIOD = 255;

    logic clk;
    logic aclr;
    int   compared;
    int   mismatched;

    pwm_audio_stereo_output_if #(.WIDTH(W)) bus ();

    pwm_audio_stereo_output #(.WIDTH(W)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full period starting at cnt==0. Expected output after edge i of the
    // period is (i < duty). New inputs may be driven after edge chg_at.
    task automatic run_period(input string name, input int exp_l, input int exp_r,
                              input int chg_at, input logic [W-1:0] nl,
                              input logic [W-1:0] nr);
        int hi_l  = 0;
        int hi_r  = 0;
        int bad_l = -1;
        int bad_r = -1;
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #1;
            if (bus.left === 1'b1) hi_l++;
            if (bus.right === 1'b1) hi_r++;
            if ((bus.left !== (i < exp_l)) && (bad_l < 0)) bad_l = i;
            if ((bus.right !== (i < exp_r)) && (bad_r < 0)) bad_r = i;
            if (i == chg_at) begin
                bus.left_top  = nl;
                bus.right_top = nr;
            end
        end
        compared++;
        if (bad_l >= 0) begin
            mismatched++;
            $display("FAIL %s left: high=%0d first_bad_phase=%0d, required high=%0d from phase 0",
                     name, hi_l, bad_l, exp_l);
        end
        compared++;
        if (bad_r >= 0) begin
            mismatched++;
            $display("FAIL %s right: high=%0d first_bad_phase=%0d, required high=%0d from phase 0",
                     name, hi_r, bad_r, exp_r);
        end
    endtask

    task automatic test_reset();
        aclr          = 1'b1;
        bus.left_top  = 8'd127;
        bus.right_top = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.left !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_left: got %b, required 0", bus.left);
        end
        compared++;
        if (bus.right !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_right: got %b, required 0", bus.right);
        end
        @(negedge clk);
        aclr = 1'b0;
        run_period("first_period_zero", 0, 0, -1, 8'd0, 8'd0);
    endtask

    task automatic test_left_only();
        run_period("left127_a", 127, 0, -1, 8'd0, 8'd0);
        run_period("left127_b", 127, 0, 10, 8'd0, 8'd127);
    endtask

    task automatic test_right_only();
        run_period("right127_a", 0, 127, -1, 8'd0, 8'd0);
        run_period("right127_b", 0, 127, 10, 8'd127, 8'd127);
    endtask

    task automatic test_both_half();
        run_period("both127_a", 127, 127, -1, 8'd0, 8'd0);
        run_period("both127_b", 127, 127, 10, 8'd255, 8'd255);
    endtask

    task automatic test_full_then_zero();
        run_period("both255_a", 255, 255, -1, 8'd0, 8'd0);
        run_period("both255_b", 255, 255, 200, 8'd0, 8'd0);
        run_period("both0", 0, 0, 20, 8'd50, 8'd0);
    endtask

    task automatic test_mid_change();
        run_period("left50_change_at100", 50, 0, 100, 8'd200, 8'd0);
        run_period("left200", 200, 0, 5, 8'd255, 8'd255);
    endtask

    task automatic test_async_reset();
        run_period("pre_reset_255", 255, 255, -1, 8'd0, 8'd0);
        repeat (40) @(posedge clk);
        #1;
        compared++;
        if ((bus.left !== 1'b1) || (bus.right !== 1'b1)) begin
            mismatched++;
            $display("FAIL pre_reset_high: got l=%b r=%b, required l=1 r=1", bus.left, bus.right);
        end
        #3;
        aclr = 1'b1;
        #1;
        compared++;
        if (bus.left !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_left: got %b, required 0 without a clock edge", bus.left);
        end
        compared++;
        if (bus.right !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_right: got %b, required 0 without a clock edge", bus.right);
        end
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ((bus.left !== 1'b0) || (bus.right !== 1'b0)) begin
            mismatched++;
            $display("FAIL reset_hold: got l=%b r=%b, required l=0 r=0", bus.left, bus.right);
        end
        @(negedge clk);
        aclr = 1'b0;
        run_period("post_reset_first", 0, 0, -1, 8'd0, 8'd0);
        run_period("post_reset_second", 255, 255, -1, 8'd0, 8'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_left_only();
        test_right_only();
        test_both_half();
        test_full_then_zero();
        test_mid_change();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
